// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier: one setup cycle, then WIDTH add/shift
// cycles on magnitudes, with the sign reapplied to the full 2*WIDTH-bit product.
module mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_mul,
  input  logic             rst,
  input  logic             mul_en,
  input  logic [WIDTH-1:0] mul_x,
  input  logic [WIDTH-1:0] mul_y,
  input  logic             mul_signed,
  output logic             stall_mul,
  output logic [WIDTH-1:0] MEM_mul_lo,
  output logic [WIDTH-1:0] MEM_mul_hi,
  output logic             MEM_mul_valid
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic               valid_q;

  logic [WIDTH-1:0]   abs_x, abs_y;
  logic               last;
  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH:0]   acc_step;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    abs_x = (mul_signed & mul_x[WIDTH-1]) ? (~mul_x + 1'b1) : mul_x;
    abs_y = (mul_signed & mul_y[WIDTH-1]) ? (~mul_y + 1'b1) : mul_y;
    last  = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));
    // The carry bit is always 0 after the previous shift, so including it in
    // the add is equivalent to adding only the hi word.
    hi_sum = acc_q[0] ? (acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q})
                      : acc_q[2*WIDTH:WIDTH];
    acc_step = {1'b0, hi_sum, acc_q[WIDTH-1:1]};
    prod = neg_q ? (~acc_q[2*WIDTH-1:0] + 1'b1) : acc_q[2*WIDTH-1:0];
  end

  assign {MEM_mul_hi, MEM_mul_lo} = prod;
  assign MEM_mul_valid = valid_q & (state_q == DONE);
  assign stall_mul     = mul_en & ~last & ~rst;

  always_ff @(posedge clk_mul) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (mul_en) begin
            mcand_q <= abs_y;
            acc_q   <= {1'b0, {WIDTH{1'b0}}, abs_x};
            neg_q   <= mul_signed & (mul_x[WIDTH-1] ^ mul_y[WIDTH-1]);
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (!mul_en) begin
            state_q <= IDLE;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: hand-computed products, stall length, valid pulse,
// back-to-back issue, abort and mid-operation reset.
module tb_mul_iter;

  logic        clk_mul = 1'b0;
  logic        rst;
  logic        mul_en;
  logic [31:0] mul_x, mul_y;
  logic        mul_signed;
  logic        stall_mul;
  logic [31:0] MEM_mul_lo, MEM_mul_hi;
  logic        MEM_mul_valid;

  int checks   = 0;
  int failures = 0;

  mul_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_mul      (clk_mul),
    .rst          (rst),
    .mul_en       (mul_en),
    .mul_x        (mul_x),
    .mul_y        (mul_y),
    .mul_signed   (mul_signed),
    .stall_mul    (stall_mul),
    .MEM_mul_lo   (MEM_mul_lo),
    .MEM_mul_hi   (MEM_mul_hi),
    .MEM_mul_valid(MEM_mul_valid)
  );

  always #5 clk_mul = ~clk_mul;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_mul);
    #1;
  endtask

  // Issue a multiply from the current cycle (IDLE or DONE), scramble operands
  // after setup, count stall cycles, and check the result in the DONE cycle.
  // Returns positioned in the DONE cycle with mul_en still high.
  task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int stall_cnt;
    stall_cnt = 0;
    mul_en = 1'b1; mul_x = x; mul_y = y; mul_signed = s;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_mul) break;
      stall_cnt++;
      tick();
      mul_x = ~x; mul_y = y ^ 32'h5A5A_A5A5; mul_signed = ~s;
      chk({tag, "_novalid_calc"}, {63'd0, MEM_mul_valid}, 64'd0);
    end
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd32);
    tick();
    chk({tag, "_valid"}, {63'd0, MEM_mul_valid}, 64'd1);
    chk({tag, "_prod"}, {MEM_mul_hi, MEM_mul_lo}, {ehi, elo});
  endtask

  task automatic finish_idle(input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    mul_en = 1'b0;
    tick();
    chk({tag, "_valid_drop"}, {63'd0, MEM_mul_valid}, 64'd0);
    chk({tag, "_held"}, {MEM_mul_hi, MEM_mul_lo}, {ehi, elo});
  endtask

  initial begin
    rst = 1'b1; mul_en = 1'b1; mul_x = '0; mul_y = '0; mul_signed = 1'b0;
    #1;
    chk("rst_stall_forced0", {63'd0, stall_mul}, 64'd0);
    tick(); tick();
    chk("rst_prod", {MEM_mul_hi, MEM_mul_lo}, 64'd0);
    chk("rst_valid", {63'd0, MEM_mul_valid}, 64'd0);
    mul_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_stall", {63'd0, stall_mul}, 64'd0);

    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "u_max");
    finish_idle(32'hFFFF_FFFE, 32'h0000_0001, "u_max");
    tick();
    chk("idle_after_hold", {MEM_mul_hi, MEM_mul_lo}, 64'hFFFF_FFFE_0000_0001);

    do_mul(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "s_m3x7");
    finish_idle(32'hFFFF_FFFF, 32'hFFFF_FFEB, "s_m3x7");
    do_mul(32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 32'h0000_0006, 32'hFFFF_FFEB, "u_m3x7");
    finish_idle(32'h0000_0006, 32'hFFFF_FFEB, "u_m3x7");
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, "s_min2");
    finish_idle(32'h4000_0000, 32'h0000_0000, "s_min2");
    do_mul(32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, "s_minx1");
    finish_idle(32'hFFFF_FFFF, 32'h8000_0000, "s_minx1");
    do_mul(32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0, 32'h0, "s_zero");
    finish_idle(32'h0, 32'h0, "s_zero");
    do_mul(32'h0000_0000, 32'h8000_0001, 1'b1, 32'h0, 32'h0, "s_zero_neg");
    finish_idle(32'h0, 32'h0, "s_zero_neg");

    // Back-to-back: the second op is set up in the DONE cycle of the first.
    do_mul(32'd5, 32'd6, 1'b0, 32'h0, 32'h1E, "b2b_a");
    do_mul(32'd5, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "b2b_b");
    finish_idle(32'hFFFF_FFFF, 32'hFFFF_FFFB, "b2b_b");

    // Abort at CALC cycle 10.
    mul_en = 1'b1; mul_x = 32'hFFFF_FFFF; mul_y = 32'hFFFF_FFFF; mul_signed = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    mul_en = 1'b0;
    #1;
    chk("abort_stall", {63'd0, stall_mul}, 64'd0);
    tick();
    chk("abort_prod", {MEM_mul_hi, MEM_mul_lo}, 64'd0);
    chk("abort_valid", {63'd0, MEM_mul_valid}, 64'd0);
    for (int i = 0; i < 35; i++) begin
      tick();
      chk("abort_no_pulse", {63'd0, MEM_mul_valid}, 64'd0);
    end

    // Reset at CALC cycle 15.
    mul_en = 1'b1; mul_x = 32'h1234_5678; mul_y = 32'h8765_4321; mul_signed = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {63'd0, stall_mul}, 64'd0);
    tick();
    chk("rst_mid_prod", {MEM_mul_hi, MEM_mul_lo}, 64'd0);
    chk("rst_mid_valid", {63'd0, MEM_mul_valid}, 64'd0);
    rst = 1'b0;
    do_mul(32'd2, 32'd3, 1'b0, 32'h0, 32'h6, "after_rst");
    finish_idle(32'h0, 32'h6, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
